// File: rtl/rob_ss.sv
// Superscalar reorder buffer.
// Allocates up to SS in-order entries per cycle, marks entries done from the
// CDB writeback ports, and retires up to SS done entries per cycle in program
// order. A flush (or reset) empties the buffer in one cycle.
module rob_ss #(
  parameter int SS        = 2,
  parameter int ROB_DEPTH = 16,
  parameter int CDB_PORTS = 2,
  parameter int PREG_W    = 6,
  parameter int AREG_W    = 5,
  localparam int IDW      = $clog2(ROB_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SS-1:0]           disp_valid,
  input  logic [SS-1:0]           disp_rd_we,
  input  logic [SS*AREG_W-1:0]    disp_rd_arch,
  input  logic [SS*PREG_W-1:0]    disp_pd,
  input  logic [SS*PREG_W-1:0]    disp_old_pd,
  output logic                    disp_ready,
  output logic [SS*IDW-1:0]       rob_id_next,
  input  logic [CDB_PORTS-1:0]    cdb_valid,
  input  logic [CDB_PORTS*IDW-1:0] cdb_rob_id,
  input  logic                    flush,
  output logic [SS-1:0]           commit_valid,
  output logic [SS*IDW-1:0]       commit_rob_id,
  output logic [SS-1:0]           commit_rd_we,
  output logic [SS*AREG_W-1:0]    commit_rd_arch,
  output logic [SS*PREG_W-1:0]    commit_pd,
  output logic [SS*PREG_W-1:0]    commit_old_pd,
  output logic                    empty,
  output logic [IDW:0]            count
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDW:0]           head_q, tail_q, head_d, tail_d;
  logic [ROB_DEPTH-1:0]   valid_q, done_q, valid_d, done_d;

  // Payload storage: written on allocation, never reset.
  logic [ROB_DEPTH-1:0]   rd_we_q;
  logic [AREG_W-1:0]      rd_arch_q [ROB_DEPTH];
  logic [PREG_W-1:0]      pd_q      [ROB_DEPTH];
  logic [PREG_W-1:0]      old_pd_q  [ROB_DEPTH];

  logic [IDW+1:0]         free_w;
  logic                   alloc_en;

  // Slot index of pointer plus lane offset, modulo the buffer depth.
  function automatic logic [IDW-1:0] slot(input logic [IDW:0] base, input int off);
    logic [IDW:0] s;
    s = base + (IDW+1)'(off);
    return s[IDW-1:0];
  endfunction

  // Number of active lanes; lanes are contiguous from lane 0.
  function automatic logic [IDW:0] lanes(input logic [SS-1:0] v);
    logic [IDW:0] n;
    n = '0;
    for (int i = 0; i < SS; i++) n = n + (IDW+1)'(v[i]);
    return n;
  endfunction

  assign count      = tail_q - head_q;
  assign empty      = (count == '0);
  assign free_w     = (IDW+2)'(ROB_DEPTH) - {1'b0, count};
  assign disp_ready = (free_w >= (IDW+2)'(SS));
  assign alloc_en   = disp_ready && !flush && !rst;

  // Next allocation IDs are taken straight from the registered tail.
  always_comb begin
    rob_id_next = '0;
    for (int i = 0; i < SS; i++) rob_id_next[i*IDW +: IDW] = slot(tail_q, i);
  end

  // In-order retirement: lane i retires only if every older lane also retires.
  always_comb begin
    logic ok;
    ok             = 1'b1;
    commit_valid   = '0;
    commit_rob_id  = '0;
    commit_rd_we   = '0;
    commit_rd_arch = '0;
    commit_pd      = '0;
    commit_old_pd  = '0;
    for (int i = 0; i < SS; i++) begin
      ok = ok && valid_q[slot(head_q, i)] && done_q[slot(head_q, i)];
      commit_valid[i]                   = ok && !flush && !rst;
      commit_rob_id[i*IDW +: IDW]       = slot(head_q, i);
      commit_rd_we[i]                   = rd_we_q[slot(head_q, i)];
      commit_rd_arch[i*AREG_W +: AREG_W] = rd_arch_q[slot(head_q, i)];
      commit_pd[i*PREG_W +: PREG_W]     = pd_q[slot(head_q, i)];
      commit_old_pd[i*PREG_W +: PREG_W] = old_pd_q[slot(head_q, i)];
    end
  end

  // Next state: completion first, then allocation, then retirement clears.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && valid_q[cdb_rob_id[p*IDW +: IDW]])
        done_d[cdb_rob_id[p*IDW +: IDW]] = 1'b1;
    end
    if (alloc_en) begin
      for (int i = 0; i < SS; i++) begin
        if (disp_valid[i]) begin
          valid_d[slot(tail_q, i)] = 1'b1;
          done_d[slot(tail_q, i)]  = 1'b0;
        end
      end
      tail_d = tail_q + lanes(disp_valid);
    end
    for (int i = 0; i < SS; i++) begin
      if (commit_valid[i]) begin
        valid_d[slot(head_q, i)] = 1'b0;
        done_d[slot(head_q, i)]  = 1'b0;
      end
    end
    head_d = head_q + lanes(commit_valid);
  end

  // Control state: reset and flush both return to the empty buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload capture for newly allocated entries.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      for (int i = 0; i < SS; i++) begin
        if (disp_valid[i]) begin
          rd_we_q[slot(tail_q, i)]   <= disp_rd_we[i];
          rd_arch_q[slot(tail_q, i)] <= disp_rd_arch[i*AREG_W +: AREG_W];
          pd_q[slot(tail_q, i)]      <= disp_pd[i*PREG_W +: PREG_W];
          old_pd_q[slot(tail_q, i)]  <= disp_old_pd[i*PREG_W +: PREG_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_ss.sv
// Testbench for rob_ss: table of per-cycle vectors plus hand-written wrap and
// reset sequences; a scoreboard queue checks retired IDs and payload.
module tb_rob_ss;

  logic        clk, rst;
  logic [1:0]  disp_valid, disp_rd_we;
  logic [9:0]  disp_rd_arch;
  logic [11:0] disp_pd, disp_old_pd;
  logic        disp_ready;
  logic [7:0]  rob_id_next;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic        flush;
  logic [1:0]  commit_valid, commit_rd_we;
  logic [7:0]  commit_rob_id;
  logic [9:0]  commit_rd_arch;
  logic [11:0] commit_pd, commit_old_pd;
  logic        empty;
  logic [4:0]  count;

  rob_ss dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_rd_we(disp_rd_we), .disp_rd_arch(disp_rd_arch),
    .disp_pd(disp_pd), .disp_old_pd(disp_old_pd), .disp_ready(disp_ready),
    .rob_id_next(rob_id_next), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .flush(flush), .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .commit_rd_we(commit_rd_we), .commit_rd_arch(commit_rd_arch),
    .commit_pd(commit_pd), .commit_old_pd(commit_old_pd),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] id;
    logic       we;
    logic [4:0] arch;
    logic [5:0] pd;
    logic [5:0] opd;
  } ent_t;

  typedef struct {
    logic [1:0] dv;
    logic [1:0] cv;
    int         id0;
    int         id1;
    logic       fl;
    int         cnt;
    logic [1:0] cmt;
    logic       rdy;
    int         nid0;
    int         cid0;
  } vec_t;

  ent_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   seq = 0;
  int   b_tail = 0;
  vec_t tv[24];

  function automatic vec_t mk(input logic [1:0] dv, input logic [1:0] cv, input int id0,
                              input int id1, input logic fl, input int cnt,
                              input logic [1:0] cmt, input logic rdy, input int nid0,
                              input int cid0);
    vec_t v;
    v.dv = dv; v.cv = cv; v.id0 = id0; v.id1 = id1; v.fl = fl;
    v.cnt = cnt; v.cmt = cmt; v.rdy = rdy; v.nid0 = nid0; v.cid0 = cid0;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the clock edge, then wait for the
  // falling edge so outputs can be sampled. Accepted lanes go to the scoreboard.
  task automatic apply(input logic [1:0] dv, input logic [1:0] cv, input int id0,
                       input int id1, input logic fl, input logic rs, input logic acc);
    ent_t e;
    int   n;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      e.id   = 4'(b_tail + i);
      e.we   = seq[0];
      e.arch = 5'(seq * 3);
      e.pd   = 6'(seq + 7);
      e.opd  = 6'(seq * 5 + 1);
      disp_rd_we[i]          = e.we;
      disp_rd_arch[i*5 +: 5] = e.arch;
      disp_pd[i*6 +: 6]      = e.pd;
      disp_old_pd[i*6 +: 6]  = e.opd;
      if (acc && dv[i] && !fl && !rs) begin
        sb.push_back(e);
        n++;
      end
      seq++;
    end
    b_tail = (b_tail + n) % 16;
    if (fl || rs) begin
      sb.delete();
      b_tail = 0;
    end
    disp_valid = dv;
    cdb_valid  = cv;
    cdb_rob_id = {4'(id1), 4'(id0)};
    flush      = fl;
    rst        = rs;
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic [1:0] cmt,
                           input logic rdy, input int nid0, input int cid0);
    chk($sformatf("%s.count", tag), int'(count), cnt);
    chk($sformatf("%s.empty", tag), int'(empty), (cnt == 0) ? 1 : 0);
    chk($sformatf("%s.disp_ready", tag), int'(disp_ready), int'(rdy));
    chk($sformatf("%s.commit_valid", tag), int'(commit_valid), int'(cmt));
    chk($sformatf("%s.rob_id_next0", tag), int'(rob_id_next[3:0]), nid0);
    chk($sformatf("%s.rob_id_next1", tag), int'(rob_id_next[7:4]), (nid0 + 1) % 16);
    if (cmt[0]) chk($sformatf("%s.commit_rob_id0", tag), int'(commit_rob_id[3:0]), cid0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every retiring lane must match the oldest outstanding allocation.
  always @(negedge clk) begin
    ent_t e, a;
    for (int i = 0; i < 2; i++) begin
      if (commit_valid[i] === 1'b1) begin
        n_chk++;
        a = {commit_rob_id[i*4 +: 4], commit_rd_we[i], commit_rd_arch[i*5 +: 5],
             commit_pd[i*6 +: 6], commit_old_pd[i*6 +: 6]};
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra lane %0d: got commit of id %0d, required no commit",
                   i, a.id);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL sb_commit lane %0d: got id=%0d we=%0d arch=%0d pd=%0d opd=%0d, required id=%0d we=%0d arch=%0d pd=%0d opd=%0d",
                     i, a.id, a.we, a.arch, a.pd, a.opd, e.id, e.we, e.arch, e.pd, e.opd);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    disp_valid = '0; disp_rd_we = '0; disp_rd_arch = '0; disp_pd = '0; disp_old_pd = '0;
    cdb_valid = '0; cdb_rob_id = '0;

    // Fill to full, in-order completion, partial commit, alloc+commit, flush, refill.
    tv[0]  = mk(2'b11, 2'b00, 0, 0, 1'b0,  0, 2'b00, 1'b1,  0, 0);
    for (int k = 1; k < 8; k++)
      tv[k] = mk(2'b11, 2'b00, 0, 0, 1'b0, 2*k, 2'b00, 1'b1, 2*k, 0);
    tv[8]  = mk(2'b11, 2'b00, 0, 0, 1'b0, 16, 2'b00, 1'b0,  0, 0);
    tv[9]  = mk(2'b00, 2'b00, 0, 0, 1'b0, 16, 2'b00, 1'b0,  0, 0);
    tv[10] = mk(2'b00, 2'b01, 1, 0, 1'b0, 16, 2'b00, 1'b0,  0, 0);
    tv[11] = mk(2'b00, 2'b00, 0, 0, 1'b0, 16, 2'b00, 1'b0,  0, 0);
    tv[12] = mk(2'b00, 2'b01, 0, 0, 1'b0, 16, 2'b00, 1'b0,  0, 0);
    tv[13] = mk(2'b00, 2'b00, 0, 0, 1'b0, 16, 2'b11, 1'b0,  0, 0);
    tv[14] = mk(2'b00, 2'b01, 2, 0, 1'b0, 14, 2'b00, 1'b1,  0, 0);
    tv[15] = mk(2'b00, 2'b01, 3, 0, 1'b0, 14, 2'b01, 1'b1,  0, 2);
    tv[16] = mk(2'b00, 2'b00, 0, 0, 1'b0, 13, 2'b01, 1'b1,  0, 3);
    tv[17] = mk(2'b00, 2'b11, 4, 4, 1'b0, 12, 2'b00, 1'b1,  0, 0);
    tv[18] = mk(2'b11, 2'b11, 5, 6, 1'b0, 12, 2'b01, 1'b1,  0, 4);
    tv[19] = mk(2'b00, 2'b00, 0, 0, 1'b0, 13, 2'b11, 1'b1,  2, 5);
    tv[20] = mk(2'b00, 2'b11, 7, 0, 1'b0, 11, 2'b00, 1'b1,  2, 0);
    tv[21] = mk(2'b11, 2'b11, 1, 8, 1'b1, 11, 2'b00, 1'b1,  2, 0);
    tv[22] = mk(2'b11, 2'b00, 0, 0, 1'b0,  0, 2'b00, 1'b1,  0, 0);
    tv[23] = mk(2'b00, 2'b00, 0, 0, 1'b0,  2, 2'b00, 1'b1,  2, 0);

    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 24; k++) begin
      apply(tv[k].dv, tv[k].cv, tv[k].id0, tv[k].id1, tv[k].fl, 1'b0, tv[k].rdy);
      chk_state($sformatf("v%0d", k), tv[k].cnt, tv[k].cmt, tv[k].rdy, tv[k].nid0, tv[k].cid0);
      step();
    end

    // Reset mid-operation with dispatch and CDB active.
    apply(2'b11, 2'b11, 0, 1, 1'b0, 1'b1, 1'b0);
    chk_state("rst_mid", 2, 2'b00, 1'b1, 2, 0);
    step();

    // Fill 14 entries, then complete and retire them two per cycle.
    for (int j = 0; j < 7; j++) begin
      apply(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
      chk_state($sformatf("fill%0d", j), 2*j, 2'b00, 1'b1, 2*j, 0);
      step();
    end
    for (int j = 0; j < 8; j++) begin
      apply(2'b00, (j < 7) ? 2'b11 : 2'b00, 2*j, 2*j+1, 1'b0, 1'b0, 1'b0);
      chk_state($sformatf("drain%0d", j), (j == 0) ? 14 : 14 - 2*(j-1),
                (j == 0) ? 2'b00 : 2'b11, 1'b1, 14, 2*(j-1));
      step();
    end

    // Head at 14: allocate across the wrap and retire {14,15} then {0}.
    apply(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    chk_state("wrap_a", 0, 2'b00, 1'b1, 14, 0);
    step();
    apply(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    chk_state("wrap_b", 2, 2'b00, 1'b1, 0, 0);
    step();
    apply(2'b00, 2'b11, 14, 15, 1'b0, 1'b0, 1'b0);
    chk_state("wrap_c", 4, 2'b00, 1'b1, 2, 0);
    step();
    apply(2'b00, 2'b11, 0, 5, 1'b0, 1'b0, 1'b0);
    chk_state("wrap_d", 4, 2'b11, 1'b1, 2, 14);
    step();
    apply(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    chk_state("wrap_e", 2, 2'b01, 1'b1, 2, 0);
    step();

    // The earlier CDB to invalid ID 5 must not leave entry 5 done.
    apply(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    chk_state("inv_f", 1, 2'b00, 1'b1, 2, 0);
    step();
    apply(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    chk_state("inv_g", 3, 2'b00, 1'b1, 4, 0);
    step();
    apply(2'b00, 2'b11, 1, 2, 1'b0, 1'b0, 1'b0);
    chk_state("inv_h", 5, 2'b00, 1'b1, 6, 0);
    step();
    apply(2'b00, 2'b11, 3, 4, 1'b0, 1'b0, 1'b0);
    chk_state("inv_i", 5, 2'b11, 1'b1, 6, 1);
    step();
    apply(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    chk_state("inv_j", 3, 2'b11, 1'b1, 6, 3);
    step();
    apply(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    chk_state("inv_k", 1, 2'b00, 1'b1, 6, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
